uart_tx_arbiter: RTL

- Shares the single board UART transmit line between several on-chip byte-stream sources, for example the MicroBlaze-side debug bridge and hardware status reporters.
- Arbitration is round-robin with packet locking: the granted source keeps the line until it sends a byte marked last, or until it stalls past a timeout.
- Contains its own 8N1 serializer.
- Sits at the top level between internal requesters and the FPGA TXD pin.

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/uart_tx_serializer.sv | 87 ++++++++
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its serializer.
package uart_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam int UART_FRAME_BITS = 10;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT cycles each.
module uart_tx_serializer
  import uart_arb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] LAST_BIT = 3'(UART_FRAME_BITS - 3);

  tx_state_t      state, state_n;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           bit_end;

  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign ready   = (state == TX_IDLE);
  assign busy    = (state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      TX_IDLE:  if (load) state_n = TX_START;
      TX_START: if (bit_end) state_n = TX_DATA;
      TX_DATA:  if (bit_end && bit_cnt == LAST_BIT) state_n = TX_STOP;
      TX_STOP:  if (bit_end) state_n = TX_IDLE;
      default:  state_n = TX_IDLE;
    endcase
  end

  // txd is registered and updated on each bit boundary so the line never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          baud_cnt <= '0;
          if (load) begin
            shreg <= data;
            txd   <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            txd      <= shreg[0];
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) txd <= 1'b1;
            else begin
              txd   <= shreg[1];
              shreg <= shreg >> 1;
            end
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        TX_STOP: begin
          if (bit_end) baud_cnt <= '0;
          else         baud_cnt <= baud_cnt + 1'b1;
        end
        default: baud_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART TXD between NUM_REQ byte streams.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int LOCK_TIMEOUT = 1_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0][7:0]    req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_txd,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);

  arb_state_t     arb, arb_n;
  logic [IW-1:0]  rr_ptr, rr_n, gid_n, pick_id, next_ptr, cand;
  logic [31:0]    stall_cnt, stall_n;
  logic           pick_found, tx_ready, accept, stall, timeout;

  assign grant_valid = (arb == ARB_LOCKED);
  assign accept      = grant_valid && req_valid[grant_id] && tx_ready;
  assign stall       = grant_valid && !req_valid[grant_id] && tx_ready;
  assign timeout     = (LOCK_TIMEOUT != 0) && stall && (stall_cnt == 32'(LOCK_TIMEOUT - 1));
  assign next_ptr    = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Scan downward so the lowest offset from rr_ptr is the one left standing.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_valid) req_ready[grant_id] = tx_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arb       <= ARB_IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      arb       <= arb_n;
      grant_id  <= gid_n;
      rr_ptr    <= rr_n;
      stall_cnt <= stall_n;
    end
  end

  always_comb begin
    arb_n   = arb;
    gid_n   = grant_id;
    rr_n    = rr_ptr;
    stall_n = stall_cnt;
    case (arb)
      ARB_IDLE: begin
        stall_n = '0;
        if (pick_found) begin
          arb_n = ARB_LOCKED;
          gid_n = pick_id;
        end
      end
      ARB_LOCKED: begin
        if (accept)     stall_n = '0;
        else if (stall) stall_n = stall_cnt + 32'd1;
        // A timeout releases exactly like a last byte, but nothing is sent.
        if ((accept && req_last[grant_id]) || timeout) begin
          arb_n   = ARB_IDLE;
          rr_n    = next_ptr;
          stall_n = '0;
        end
      end
      default: arb_n = ARB_IDLE;
    endcase
  end

  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .data  (req_data[grant_id]),
    .ready (tx_ready),
    .txd   (uart_txd),
    .busy  (busy)
  );

endmodule
